uart: RTL and testbench

//  Full-duplex 8N1 UART: one byte-wide transmitter and one receiver with a sticky ready flag.

---
 rtl/uart.sv | 208 ++++++++++++++++++++
 tb/tb_uart.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// 8N1 UART: independent transmitter and 16x-oversampling receiver with a sticky ready flag.
// Everything runs on clk_50m with a synchronous active-high reset.
module uart #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);
    localparam int unsigned TX_DIV = CLK_FREQ / BAUD;
    localparam int unsigned RX_DIV = CLK_FREQ / (BAUD * 16);
    localparam int TXW = $clog2(TX_DIV);
    localparam int RXW = $clog2(RX_DIV);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // ---------------- transmitter ----------------
    state_e           tx_state_q, tx_state_d;
    logic [TXW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shr_q, tx_shr_d;
    logic             tx_q, tx_d;
    logic             tx_busy_q, tx_busy_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shr_d   = tx_shr_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        if (tx_state_q != S_IDLE) begin
            tx_cnt_d = (tx_cnt_q == TX_LAST) ? '0 : tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            S_IDLE: begin
                if (wr_en) begin
                    tx_shr_d   = din;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_cnt_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == TX_LAST) begin
                    tx_idx_d   = 3'd0;
                    tx_d       = tx_shr_q[0];
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == TX_LAST) begin
                    if (tx_idx_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_d     = tx_shr_q[tx_idx_q + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (tx_cnt_q == TX_LAST) begin
                    tx_busy_d  = 1'b0;
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shr_q   <= 8'h00;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shr_q   <= tx_shr_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    // ---------------- receiver ----------------
    logic             rx_s1_q, rx_s2_q;
    state_e           rx_state_q, rx_state_d;
    logic [RXW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]       os_cnt_q, os_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shr_q, rx_shr_d;
    logic             rdy_q, rdy_d;
    logic [7:0]       dout_q, dout_d;
    logic             tick;
    logic             rx_done;

    assign tick = (tick_cnt_q == RX_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        os_cnt_d   = os_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shr_d   = rx_shr_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                // Realign the oversample grid to the falling edge of the start bit.
                if (!rx_s2_q) begin
                    tick_cnt_d = '0;
                    os_cnt_d   = 4'd0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (os_cnt_q == 4'd7) begin
                        os_cnt_d   = 4'd0;
                        rx_idx_d   = 3'd0;
                        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        rx_shr_d = {rx_s2_q, rx_shr_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_state_d = S_STOP;
                        end else begin
                            rx_idx_d = rx_idx_q + 3'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        rx_done    = rx_s2_q;
                        rx_state_d = S_IDLE;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase

        rdy_d  = rdy_q;
        dout_d = dout_q;
        if (rdy_clr) begin
            rdy_d = 1'b0;
        end
        // A completing byte beats a simultaneous clear.
        if (rx_done) begin
            rdy_d  = 1'b1;
            dout_d = rx_shr_q;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            tick_cnt_q <= '0;
            os_cnt_q   <= 4'd0;
            rx_idx_q   <= 3'd0;
            rx_shr_q   <= 8'h00;
            rdy_q      <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            tick_cnt_q <= tick_cnt_d;
            os_cnt_q   <= os_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shr_q   <= rx_shr_d;
            rdy_q      <= rdy_d;
            dout_q     <= dout_d;
        end
    end

    assign rdy  = rdy_q;
    assign dout = dout_q;
endmodule

// File: tb/tb_uart.sv
// Directed and randomized checks of the 8N1 UART against a line-level model of the frame.
module tb_uart;
    localparam int BIT = 434;

    logic       clk_50m = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] din     = 8'h00;
    logic       wr_en   = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       rx_drive = 1'b1;
    logic       loop_en  = 1'b0;
    logic       rx_line;
    logic       rdy;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    logic       exp_rdy  = 1'b0;
    logic [7:0] exp_dout = 8'h00;

    assign rx_line = loop_en ? tx : rx_drive;

    uart dut (
        .clk_50m(clk_50m), .reset(reset), .din(din), .wr_en(wr_en),
        .tx(tx), .tx_busy(tx_busy), .rx(rx_line), .rdy(rdy),
        .rdy_clr(rdy_clr), .dout(dout)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Line value in each of the 10 bit slots of an 8N1 frame (slot 0 = start).
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Mid-slot line values seen for a single low pulse of w clocks.
    function automatic logic [9:0] pulse_samples(input int w);
        logic [9:0] s;
        for (int k = 0; k < 10; k++) s[k] = (k * BIT + BIT / 2 < w) ? 1'b0 : 1'b1;
        return s;
    endfunction

    task automatic tx_frame(input logic [7:0] b, input bit hold,
                            output logic [9:0] bits, output int busy_cnt);
        @(negedge clk_50m);
        din = b; wr_en = 1'b1;
        @(negedge clk_50m);
        if (!hold) wr_en = 1'b0;
        busy_cnt = 0;
        bits = '0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc > 0) @(negedge clk_50m);
            if (cyc % BIT == BIT / 2 && cyc / BIT < 10) bits[cyc / BIT] = tx;
            if (tx_busy) busy_cnt++;
            else begin
                wr_en = 1'b0;
                break;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop, input int clr_at,
                            output int rise_at);
        logic [9:0] f;
        int slot;
        f = frame_of(b);
        f[9] = stop;
        rise_at = -1;
        for (int cyc = 0; cyc < 10 * BIT; cyc++) begin
            @(negedge clk_50m);
            if (rdy === 1'b1 && rise_at < 0) rise_at = cyc;
            slot = cyc / BIT;
            rx_drive = (slot == 9 && cyc % BIT >= 300) ? 1'b1 : f[slot];
            rdy_clr = (cyc == clr_at);
        end
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        rx_drive = 1'b1;
    endtask

    task automatic clear_rdy(input string tag);
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        exp_rdy = 1'b0;
        check(tag, rdy, exp_rdy);
    endtask

    task automatic rx_pulse(input int w);
        logic [9:0] s;
        for (int c = 0; c < w; c++) begin
            @(negedge clk_50m);
            rx_drive = 1'b0;
        end
        @(negedge clk_50m);
        rx_drive = 1'b1;
        repeat (4600) @(negedge clk_50m);
        s = pulse_samples(w);
        if (s[0] == 1'b0 && s[9] == 1'b1) begin
            exp_rdy  = 1'b1;
            exp_dout = s[8:1];
        end
    endtask

    initial begin
        logic [9:0] bits;
        int busy_cnt;
        int rise;
        int dummy;
        logic [7:0] b;
        bit stop;

        // Reset for two clocks.
        repeat (2) @(posedge clk_50m);
        @(negedge clk_50m);
        reset = 1'b0;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_rdy", rdy, 1'b0);
        check("reset_dout", dout, 8'h00);

        // Single-clock request for 0xA5.
        tx_frame(8'hA5, 1'b0, bits, busy_cnt);
        check("tx_a5_bits", bits, frame_of(8'hA5));
        check("tx_a5_busy_len", busy_cnt, 10 * BIT);

        // Request held through a whole frame produces exactly one frame.
        b = 8'($urandom);
        tx_frame(b, 1'b1, bits, busy_cnt);
        check("tx_hold_bits", bits, frame_of(b));
        check("tx_hold_busy_len", busy_cnt, 10 * BIT);
        repeat (3) @(negedge clk_50m);
        check("tx_hold_no_extra", tx_busy, 1'b0);
        check("tx_hold_line_idle", tx, 1'b1);

        // Loopback 0x3C, then a few random bytes.
        loop_en = 1'b1;
        tx_frame(8'h3C, 1'b0, bits, busy_cnt);
        exp_rdy = 1'b1; exp_dout = 8'h3C;
        check("loop_3c_bits", bits, frame_of(8'h3C));
        check("loop_3c_rdy", rdy, exp_rdy);
        check("loop_3c_dout", dout, exp_dout);
        clear_rdy("loop_3c_clr");
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            tx_frame(b, 1'b0, bits, busy_cnt);
            exp_rdy = 1'b1; exp_dout = b;
            check("loop_rand_bits", bits, frame_of(b));
            check("loop_rand_rdy", rdy, exp_rdy);
            check("loop_rand_dout", dout, exp_dout);
            clear_rdy("loop_rand_clr");
        end
        loop_en = 1'b0;

        // Short glitch is rejected; a three-bit-wide low pulse decodes as a real frame.
        rx_pulse(100);
        check("glitch_rdy", rdy, exp_rdy);
        check("glitch_dout", dout, exp_dout);
        rx_pulse(1300);
        check("pulse3_rdy", rdy, exp_rdy);
        check("pulse3_dout", dout, exp_dout);
        clear_rdy("pulse3_clr");

        // Framing error: stop bit low.
        rx_frame(8'h81, 1'b0, -1, dummy);
        repeat (600) @(negedge clk_50m);
        check("framing_rdy", rdy, exp_rdy);
        check("framing_dout", dout, exp_dout);

        // Back-to-back 0x01 then 0xFF, clearing on the 0xFF completion edge.
        rx_frame(8'h01, 1'b1, -1, rise);
        exp_rdy = 1'b1; exp_dout = 8'h01;
        check("b2b_01_seen", rise >= 0, 1'b1);
        check("b2b_01_dout", dout, exp_dout);
        rx_frame(8'hFF, 1'b1, rise - 1, dummy);
        exp_rdy = 1'b1; exp_dout = 8'hFF;
        check("b2b_ff_rdy", rdy, exp_rdy);
        check("b2b_ff_dout", dout, exp_dout);

        // Random bytes straight on rx, some with bad stop bits, without clearing (overrun).
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rx_frame(b, stop, -1, dummy);
            repeat (600) @(negedge clk_50m);
            if (stop) begin
                exp_rdy = 1'b1; exp_dout = b;
            end
            check("rx_rand_rdy", rdy, exp_rdy);
            check("rx_rand_dout", dout, exp_dout);
        end

        // Reset in the middle of data bit slot 4.
        b = 8'($urandom);
        @(negedge clk_50m);
        din = b; wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        repeat (4 * BIT + BIT / 2) @(negedge clk_50m);
        check("midtx_bit4", tx, frame_of(b) >> 4 & 10'h1);
        reset = 1'b1;
        @(negedge clk_50m);
        reset = 1'b0;
        exp_rdy = 1'b0; exp_dout = 8'h00;
        check("midtx_reset_tx", tx, 1'b1);
        check("midtx_reset_busy", tx_busy, 1'b0);
        check("midtx_reset_rdy", rdy, exp_rdy);
        check("midtx_reset_dout", dout, exp_dout);
        tx_frame(8'h00, 1'b0, bits, busy_cnt);
        check("after_reset_bits", bits, frame_of(8'h00));
        check("after_reset_busy_len", busy_cnt, 10 * BIT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
